// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: load codes, FSM states, bus widths.
package mem_wb_stage_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LBU = 3'd1,
    LT_LH  = 3'd2,
    LT_LHU = 3'd3,
    LT_LW  = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load alignment: byte 0 lives in bits 31:24 of the bus word.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic [2:0]        load_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to the load code
  always_comb begin
    byte_sel = rdata[8*(3-addr_lo) +: 8];
    half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    data     = rdata;
    case (load_type)
      LT_LB:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
      LT_LH:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LT_LHU:  data = {{(DATA_W-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: accepts one retiring instruction, waits on loads, drives a
// single registered register-file write pulse per instruction.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int REG_AW = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic              dbus_ack,
  input  logic              dbus_err,
  input  logic [DATA_W-1:0] dbus_rdata,
  input  logic              flush,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              stall_req,
  output logic              load_err
);

  state_e state, nxt;

  logic              lat_wreg;
  logic [REG_AW-1:0] lat_dest;
  logic [2:0]        lat_type;
  logic [1:0]        lat_lo;

  logic              accept, in_wait, wr, err_n;
  logic              sel_wreg;
  logic [REG_AW-1:0] sel_dest;
  logic [2:0]        sel_type;
  logic [1:0]        sel_lo;
  logic [DATA_W-1:0] aligned, sel_data;

  assign mem_ready = (state == ST_IDLE) || (state == ST_WB);
  assign stall_req = (state == ST_WAIT);
  assign accept    = mem_valid & mem_ready & ~flush;
  assign in_wait   = (state == ST_WAIT);

  // In WAIT the instruction fields come from the latch; otherwise straight
  // from the MEM stage (covers zero-wait loads and non-loads).
  assign sel_wreg = in_wait ? lat_wreg : mem_wreg;
  assign sel_dest = in_wait ? lat_dest : mem_wd;
  assign sel_type = in_wait ? lat_type : mem_load_type;
  assign sel_lo   = in_wait ? lat_lo   : mem_addr_lo;
  assign sel_data = (in_wait || mem_is_load) ? aligned : mem_wdata;

  load_align #(.DATA_W(DATA_W)) u_align (
    .load_type (sel_type),
    .addr_lo   (sel_lo),
    .rdata     (dbus_rdata),
    .data      (aligned)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  // Next state and write/error decisions; flush beats accept and ack
  always_comb begin
    nxt   = ST_IDLE;
    wr    = 1'b0;
    err_n = 1'b0;
    if (!flush) begin
      case (state)
        ST_IDLE, ST_WB: begin
          if (accept) begin
            if (!mem_is_load) begin
              nxt = ST_WB;
              wr  = 1'b1;
            end else if (dbus_ack && !dbus_err) begin
              nxt = ST_WB;
              wr  = 1'b1;
            end else if (dbus_ack && dbus_err) begin
              err_n = 1'b1;
            end else begin
              nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dbus_ack && !dbus_err) begin
            nxt = ST_WB;
            wr  = 1'b1;
          end else if (dbus_ack && dbus_err) begin
            err_n = 1'b1;
          end else begin
            nxt = ST_WAIT;
          end
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // Capture instruction fields on accept for use while waiting on the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_wreg <= 1'b0;
      lat_dest <= '0;
      lat_type <= '0;
      lat_lo   <= '0;
    end else if (accept) begin
      lat_wreg <= mem_wreg;
      lat_dest <= mem_wd;
      lat_type <= mem_load_type;
      lat_lo   <= mem_addr_lo;
    end
  end

  // Registered write-back port and error pulse; r0 writes keep addr/data
  // updated but never assert the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      load_err <= 1'b0;
    end else begin
      wb_we    <= wr & sel_wreg & (|sel_dest);
      load_err <= err_n;
      if (wr) begin
        wb_waddr <= sel_dest;
        wb_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes expected writes/errors,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready, mem_wreg, mem_is_load;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, dbus_rdata;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic        dbus_ack, dbus_err, flush;
  logic        wb_we, stall_req, load_err;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  int  err_exp = 0;
  int  checks = 0, errors = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .mem_is_load(mem_is_load), .mem_load_type(mem_load_type),
    .mem_addr_lo(mem_addr_lo), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
    .dbus_rdata(dbus_rdata), .flush(flush), .wb_we(wb_we),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .stall_req(stall_req),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  // Monitor: every write pulse and every error pulse must match a queued expectation
  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got waddr=%0d wdata=%h, required no write", wb_waddr, wb_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wb_waddr !== e.a || wb_wdata !== e.d) begin
          errors++;
          $display("FAIL wb_data: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                   wb_waddr, wb_wdata, e.a, e.d);
        end
      end
    end
    if (load_err === 1'b1) begin
      checks++;
      if (err_exp == 0) begin
        errors++;
        $display("FAIL load_err_unexpected: got 1, required 0");
      end else err_exp--;
    end
  end

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    mem_valid = 0; mem_wreg = 0; mem_wd = 0; mem_wdata = 0; mem_is_load = 0;
    mem_load_type = 0; mem_addr_lo = 0; dbus_ack = 0; dbus_err = 0; flush = 0;
  endtask

  task automatic present(input logic ld, input logic [2:0] lt, input logic [1:0] lo,
                         input logic [4:0] wd, input logic [31:0] wdata);
    mem_valid = 1; mem_wreg = 1; mem_is_load = ld; mem_load_type = lt;
    mem_addr_lo = lo; mem_wd = wd; mem_wdata = wdata;
  endtask

  // LB/LBU with three WAIT cycles, ack on the third
  task automatic wait_load(input logic [2:0] lt, input logic [4:0] wd, input logic [31:0] req);
    int stalls = 0;
    present(1, lt, 2'd1, wd, 32'h0);
    dbus_rdata = 32'h11F2_3344;
    step(); idle_in();
    for (int i = 0; i < 3; i++) begin
      dbus_ack = (i == 2);
      if (i == 2) expect_wr(wd, req);
      @(negedge clk);
      if (stall_req) stalls++;
      step();
    end
    idle_in();
    @(negedge clk);
    chk("wait_stall_cycles", stalls, 3);
    chk("wait_stall_after", stall_req, 0);
    step();
  endtask

  initial begin
    idle_in();
    dbus_rdata = 0;
    rst = 0;
    #12;
    chk("rst_we", wb_we, 0);
    chk("rst_waddr", wb_waddr, 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_ready", mem_ready, 1);
    chk("rst_stall", stall_req, 0);
    rst = 1;
    step();

    // Non-load, latency one
    present(0, 3'd0, 2'd0, 5'd5, 32'h1234_5678);
    expect_wr(5'd5, 32'h1234_5678);
    @(negedge clk); chk("nonload_stall", stall_req, 0);
    step(); idle_in();
    @(negedge clk); chk("nonload_we_hi", wb_we, 1);
    step();
    @(negedge clk); chk("nonload_we_single", wb_we, 0);
    step();

    wait_load(3'd0, 5'd7, 32'hFFFF_FFF2);
    wait_load(3'd1, 5'd8, 32'h0000_00F2);

    // Zero-wait back-to-back: LH, LHU, LW
    dbus_rdata = 32'h8001_7FFE; dbus_ack = 1;
    present(1, 3'd2, 2'd0, 5'd1, 0); expect_wr(5'd1, 32'hFFFF_8001); step();
    present(1, 3'd3, 2'd2, 5'd2, 0); expect_wr(5'd2, 32'h0000_7FFE);
    @(negedge clk); chk("b2b_we0", wb_we, 1); step();
    present(1, 3'd4, 2'd0, 5'd3, 0); expect_wr(5'd3, 32'h8001_7FFE);
    @(negedge clk); chk("b2b_we1", wb_we, 1); step();
    idle_in();
    @(negedge clk); chk("b2b_we2", wb_we, 1); step();

    // Bus error in WAIT
    present(1, 3'd4, 2'd0, 5'd9, 0); step(); idle_in();
    dbus_ack = 1; dbus_err = 1; err_exp++; step(); idle_in();
    @(negedge clk);
    chk("err_pulse", load_err, 1);
    chk("err_ready", mem_ready, 1);
    chk("err_no_we", wb_we, 0);
    step();
    @(negedge clk); chk("err_single", load_err, 0);
    step();

    // Flush with ack in WAIT, then r0 write
    present(1, 3'd4, 2'd0, 5'd10, 0); step(); idle_in();
    flush = 1; dbus_ack = 1; dbus_rdata = 32'hCAFE_0000; step(); idle_in();
    @(negedge clk);
    chk("flush_ready", mem_ready, 1);
    chk("flush_no_err", load_err, 0);
    present(0, 3'd0, 2'd0, 5'd0, 32'hDEAD_BEEF); step(); idle_in();
    @(negedge clk);
    chk("r0_we", wb_we, 0);
    chk("r0_waddr", wb_waddr, 0);
    chk("r0_wdata", wb_wdata, 32'hDEAD_BEEF);
    step();

    // Async reset mid-WAIT, then a stale ack
    present(1, 3'd0, 2'd0, 5'd12, 0); step(); idle_in();
    @(negedge clk); chk("ar_stall_before", stall_req, 1);
    #1 rst = 0;
    #1;
    chk("ar_wdata", wb_wdata, 0);
    chk("ar_stall", stall_req, 0);
    chk("ar_ready", mem_ready, 1);
    #1 rst = 1;
    step();
    dbus_ack = 1; dbus_rdata = 32'h5555_5555; step(); idle_in();
    @(negedge clk); chk("ar_stale_ack", wb_we, 0);
    step();

    present(0, 3'd0, 2'd0, 5'd31, 32'hA5A5_5A5A); expect_wr(5'd31, 32'hA5A5_5A5A);
    step(); idle_in();
    repeat (3) step();

    chk("queue_drained", exp_q.size(), 0);
    chk("err_drained", err_exp, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
